coax_spi_host: RTL

//  SPI host (controller) for the coax interface's SPI device port: the other end of the link the host MCU normally drives.

---
 rtl/coax_spi_host_if.sv | 21 ++
 rtl/coax_spi_host.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/coax_spi_host_if.sv
// Byte-stream port of the SPI host: transmit bytes with frame markers in, received bytes out.
interface coax_spi_host_if;
    logic [7:0] tx_data;
    logic       tx_last;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_strobe;

    // Upstream byte source / sink.
    modport master (
        output tx_data, tx_last, tx_valid,
        input  tx_ready, rx_data, rx_strobe
    );

    // The SPI host itself.
    modport slave (
        input  tx_data, tx_last, tx_valid,
        output tx_ready, rx_data, rx_strobe
    );
endinterface

// File: rtl/coax_spi_host.sv
// Mode-0 SPI host: turns a framed byte stream into CS-bracketed SPI transfers
// and returns the byte clocked back from the device for each byte sent.
module coax_spi_host #(
    parameter int unsigned CLOCKS_PER_HALF_SCK = 2,
    parameter int unsigned CS_SETUP_CLOCKS     = 2,
    parameter int unsigned CS_HOLD_CLOCKS      = 2,
    parameter int unsigned CS_IDLE_CLOCKS      = 4
) (
    input  logic             clk,
    input  logic             reset,
    output logic             spi_sck,
    output logic             spi_cs,
    output logic             spi_sdo,
    input  logic             spi_sdi,
    output logic             busy,
    coax_spi_host_if.slave   strm
);

    localparam int unsigned MAX_AB = (CLOCKS_PER_HALF_SCK > CS_SETUP_CLOCKS) ? CLOCKS_PER_HALF_SCK : CS_SETUP_CLOCKS;
    localparam int unsigned MAX_CD = (CS_HOLD_CLOCKS > CS_IDLE_CLOCKS) ? CS_HOLD_CLOCKS : CS_IDLE_CLOCKS;
    localparam int unsigned MAX_P  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int unsigned CNT_W  = $clog2(MAX_P + 1);

    localparam logic [CNT_W-1:0] HALF_END  = CNT_W'(CLOCKS_PER_HALF_SCK - 1);
    localparam logic [CNT_W-1:0] SETUP_END = CNT_W'(CS_SETUP_CLOCKS - 1);
    localparam logic [CNT_W-1:0] HOLD_END  = CNT_W'(CS_HOLD_CLOCKS - 1);
    localparam logic [CNT_W-1:0] GAP_END   = CNT_W'(CS_IDLE_CLOCKS - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT_LOW,
        SHIFT_HIGH,
        BYTE_WAIT,
        HOLD,
        GAP
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       tx_sh_q, tx_sh_d;
    logic [7:0]       rx_sh_q, rx_sh_d;
    logic             last_q, last_d;
    logic             sck_q, sck_d;
    logic             cs_q, cs_d;
    logic             sdo_q, sdo_d;
    logic             tx_ready_q, tx_ready_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             rx_strobe_q, rx_strobe_d;
    logic             busy_q, busy_d;
    logic             accept;

    assign accept = strm.tx_valid && tx_ready_q;

    // State and output registers; everything returns to idle values on reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            tx_sh_q     <= '0;
            rx_sh_q     <= '0;
            last_q      <= 1'b0;
            sck_q       <= 1'b0;
            cs_q        <= 1'b1;
            sdo_q       <= 1'b0;
            tx_ready_q  <= 1'b0;
            rx_data_q   <= '0;
            rx_strobe_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            tx_sh_q     <= tx_sh_d;
            rx_sh_q     <= rx_sh_d;
            last_q      <= last_d;
            sck_q       <= sck_d;
            cs_q        <= cs_d;
            sdo_q       <= sdo_d;
            tx_ready_q  <= tx_ready_d;
            rx_data_q   <= rx_data_d;
            rx_strobe_q <= rx_strobe_d;
            busy_q      <= busy_d;
        end
    end

    // Next-state and next-output logic for the frame sequencer.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        tx_sh_d     = tx_sh_q;
        rx_sh_d     = rx_sh_q;
        last_d      = last_q;
        sck_d       = sck_q;
        cs_d        = cs_q;
        sdo_d       = sdo_q;
        rx_data_d   = rx_data_q;
        rx_strobe_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    tx_sh_d = strm.tx_data;
                    last_d  = strm.tx_last;
                    sdo_d   = strm.tx_data[7];
                    cs_d    = 1'b0;
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (cnt_q == SETUP_END) begin
                    cnt_d   = '0;
                    state_d = SHIFT_LOW;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            SHIFT_LOW: begin
                // Rising edge: capture the device bit.
                if (cnt_q == HALF_END) begin
                    cnt_d   = '0;
                    sck_d   = 1'b1;
                    rx_sh_d = {rx_sh_q[6:0], spi_sdi};
                    state_d = SHIFT_HIGH;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            SHIFT_HIGH: begin
                // Falling edge: advance sdo, or close the byte after bit 0.
                if (cnt_q == HALF_END) begin
                    cnt_d = '0;
                    sck_d = 1'b0;
                    if (bit_q == 3'd7) begin
                        bit_d       = '0;
                        rx_data_d   = rx_sh_q;
                        rx_strobe_d = 1'b1;
                        state_d     = last_q ? HOLD : BYTE_WAIT;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        sdo_d   = tx_sh_q[6];
                        tx_sh_d = {tx_sh_q[6:0], 1'b0};
                        state_d = SHIFT_LOW;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            BYTE_WAIT: begin
                if (accept) begin
                    tx_sh_d = strm.tx_data;
                    last_d  = strm.tx_last;
                    sdo_d   = strm.tx_data[7];
                    cnt_d   = '0;
                    state_d = SHIFT_LOW;
                end
            end
            HOLD: begin
                if (cnt_q == HOLD_END) begin
                    cnt_d   = '0;
                    cs_d    = 1'b1;
                    sdo_d   = 1'b0;
                    state_d = GAP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            GAP: begin
                if (cnt_q == GAP_END) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        tx_ready_d = (state_d == IDLE) || (state_d == BYTE_WAIT);
        busy_d     = (state_d != IDLE);
    end

    assign spi_sck        = sck_q;
    assign spi_cs         = cs_q;
    assign spi_sdo        = sdo_q;
    assign busy           = busy_q;
    assign strm.tx_ready  = tx_ready_q;
    assign strm.rx_data   = rx_data_q;
    assign strm.rx_strobe = rx_strobe_q;

endmodule
